// File: rtl/ledsuit_pkg.sv
// Shared constants and scheduler state type
// for the LED suit frame memory.
package ledsuit_pkg;
  localparam int NUM_LEDS      = 72;
  localparam int NUM_DRIVERS   = 2;
  localparam int NUM_CHANNELS  = NUM_LEDS * 3;
  localparam int ADDRESS_WIDTH = 9;
  localparam int DATA_WIDTH    = 8;
  localparam int DEPTH         = NUM_DRIVERS * NUM_CHANNELS;
  localparam int MAX_WR_BURST  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RSP
  } state_t;
endpackage

// File: rtl/frame_ram_scheduler_if.sv
// Writer and strip-driver request/response
// bundle for the frame RAM scheduler.
interface frame_ram_scheduler_if #(
  parameter int DATA_WIDTH    = ledsuit_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = ledsuit_pkg::ADDRESS_WIDTH,
  parameter int NUM_READERS   = ledsuit_pkg::NUM_DRIVERS
);
  logic                               wr_req;
  logic [ADDRESS_WIDTH-1:0]           wr_addr;
  logic [DATA_WIDTH-1:0]              wr_data;
  logic                               wr_ack;
  logic [NUM_READERS-1:0]             rd_req;
  logic [NUM_READERS*ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic [NUM_READERS-1:0]             rd_rdy;
  logic                               busy;

  modport master (
    output wr_req, wr_addr, wr_data,
    output rd_req, rd_addr,
    input  wr_ack, rd_data, rd_rdy, busy
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr,
    output wr_ack, rd_data, rd_rdy, busy
  );
endinterface

// File: rtl/frame_ram_scheduler_ram.sv
// Single-port pixel RAM with registered read;
// storage has no reset so it maps onto EBR.
module frame_ram #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int DEPTH         = 432
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    q
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      q <= mem[addr];
    end
  end
endmodule

// File: rtl/frame_ram_scheduler.sv
// Serialises SPI byte writes and strip-driver
// reads onto the single frame RAM port.
module frame_ram_scheduler
  import ledsuit_pkg::*;
#(
  parameter int DATA_WIDTH    = ledsuit_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = ledsuit_pkg::ADDRESS_WIDTH,
  parameter int DEPTH         = ledsuit_pkg::DEPTH,
  parameter int NUM_READERS   = ledsuit_pkg::NUM_DRIVERS,
  parameter int MAX_WR_BURST  = ledsuit_pkg::MAX_WR_BURST
) (
  input logic clk,
  input logic resetn,
  frame_ram_scheduler_if.slave bus
);
  localparam int IDX_W =
    (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;
  localparam int CNT_W = $clog2(MAX_WR_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_WR_BURST);

  state_t                   state;
  state_t                   nxt;
  logic [IDX_W-1:0]         grant;
  logic [IDX_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]         burst_cnt;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;

  logic                     rd_pend;
  logic                     rd_found;
  logic [IDX_W-1:0]         sel;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic                     wr_go;
  logic                     rd_go;
  logic                     ram_we;
  logic                     ram_re;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_q;
  logic                     q_in_range;

  assign rd_pend = |bus.rd_req;

  // Round-robin search begins just after the last served reader.
  always_comb begin
    int idx;
    idx      = 0;
    rd_found = 1'b0;
    sel      = rr_ptr;
    for (int i = 1; i <= NUM_READERS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_READERS;
      if (!rd_found && bus.rd_req[idx]) begin
        rd_found = 1'b1;
        sel      = IDX_W'(idx);
      end
    end
  end

  assign sel_addr =
    bus.rd_addr[int'(sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];

  always_comb begin
    nxt   = state;
    wr_go = 1'b0;
    rd_go = 1'b0;
    unique case (state)
      IDLE: begin
        wr_go = bus.wr_req &&
                !(burst_cnt == CNT_MAX && rd_pend);
        rd_go = !wr_go && rd_found;
        if (wr_go) begin
          nxt = WR;
        end else if (rd_go) begin
          nxt = RD;
        end
      end
      WR:      nxt = IDLE;
      RD:      nxt = RSP;
      RSP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // The read is issued from IDLE so data is ready by the end of RD.
  assign ram_addr   = (state == IDLE) ? sel_addr : addr_q;
  assign ram_re     = rd_go && (32'(sel_addr) < DEPTH);
  assign ram_we     = (state == WR) && (32'(addr_q) < DEPTH);
  assign q_in_range = 32'(addr_q) < DEPTH;

  frame_ram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DEPTH        (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(data_q),
    .q    (ram_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= IDX_W'(NUM_READERS - 1);
      burst_cnt   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      bus.wr_ack  <= 1'b0;
      bus.rd_rdy  <= '0;
      bus.rd_data <= '0;
      bus.busy    <= 1'b0;
    end else begin
      state      <= nxt;
      bus.busy   <= (nxt != IDLE);
      bus.wr_ack <= wr_go;
      bus.rd_rdy <= '0;
      if (state == IDLE) begin
        if (wr_go) begin
          addr_q <= bus.wr_addr;
          data_q <= bus.wr_data;
          if (rd_pend && burst_cnt != CNT_MAX) begin
            burst_cnt <= burst_cnt + 1'b1;
          end else if (!rd_pend) begin
            burst_cnt <= '0;
          end
        end else if (rd_go) begin
          addr_q    <= sel_addr;
          grant     <= sel;
          rr_ptr    <= sel;
          burst_cnt <= '0;
        end else if (!rd_pend) begin
          burst_cnt <= '0;
        end
      end
      if (state == RD) begin
        bus.rd_data <= q_in_range ? ram_q : '0;
        bus.rd_rdy  <= NUM_READERS'(1) << grant;
      end
    end
  end
endmodule

// File: tb/tb_frame_ram_scheduler.sv
// Directed self-checking bench for the
// frame RAM scheduler.
module tb_frame_ram_scheduler;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int passed = 0;
  int total = 0;

  frame_ram_scheduler_if bus ();

  frame_ram_scheduler dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [8:0] a,
                          input logic [7:0] d,
                          input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    bus.wr_req = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (bus.wr_ack) seen = 1;
    end
    bus.wr_req = 1'b0;
    check({tag, "_lat"}, n, 1);
    tick();
    check({tag, "_ack1"}, bus.wr_ack, 0);
  endtask

  task automatic do_read(input int idx,
                         input logic [8:0] a,
                         input logic [7:0] d,
                         input string tag);
    int n;
    bit seen;
    logic [1:0] rdy;
    logic [7:0] dat;
    n = 0;
    seen = 0;
    rdy = '0;
    dat = '0;
    bus.rd_addr[idx*9 +: 9] = a;
    bus.rd_req[idx] = 1'b1;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (bus.rd_rdy != 0) begin
        seen = 1;
        rdy = bus.rd_rdy;
        dat = bus.rd_data;
      end
    end
    bus.rd_req[idx] = 1'b0;
    check({tag, "_lat"}, n, 2);
    check({tag, "_rdy"}, rdy, 2'b01 << idx);
    check({tag, "_data"}, dat, d);
    tick();
  endtask

  initial begin
    logic [1:0] rdys [4];
    logic [7:0] dats [4];
    int cyc [4];
    int k, n, wb, wa, ac, rc;
    bit rs;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req = '0;
    bus.rd_addr = '0;

    tick();
    tick();
    check("rst_wr_ack", bus.wr_ack, 0);
    check("rst_rd_rdy", bus.rd_rdy, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_data", bus.rd_data, 0);
    resetn = 1'b1;
    tick();

    do_write(9'd5, 8'hA5, "w5");
    do_read(0, 9'd5, 8'hA5, "r5");

    do_write(9'd10, 8'h11, "w10");
    do_write(9'd226, 8'h22, "w226");
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    bus.rd_addr[0 +: 9] = 9'd10;
    bus.rd_addr[9 +: 9] = 9'd226;
    bus.rd_req = 2'b11;
    k = 0;
    n = 0;
    while (k < 4 && n < 40) begin
      tick();
      n++;
      if (bus.rd_rdy != 0) begin
        rdys[k] = bus.rd_rdy;
        dats[k] = bus.rd_data;
        cyc[k] = n;
        k++;
      end
    end
    bus.rd_req = 2'b00;
    check("rr_count", k, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_rdy%0d", i), rdys[i],
            (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr_data%0d", i), dats[i],
            (i % 2 == 0) ? 8'h11 : 8'h22);
    end
    for (int i = 1; i < 4; i++) begin
      check($sformatf("rr_gap%0d", i),
            cyc[i] - cyc[i-1], 3);
    end
    tick();

    bus.wr_addr = 9'd100;
    bus.wr_data = 8'h55;
    bus.rd_addr[0 +: 9] = 9'd10;
    bus.wr_req = 1'b1;
    bus.rd_req = 2'b01;
    wb = 0;
    wa = 0;
    rs = 0;
    n = 0;
    rdys[0] = '0;
    dats[0] = '0;
    while (wa == 0 && n < 60) begin
      tick();
      n++;
      if (bus.wr_ack) begin
        if (!rs) wb++;
        else begin
          wa++;
          bus.wr_req = 1'b0;
        end
      end
      if (bus.rd_rdy != 0) begin
        rs = 1;
        rdys[0] = bus.rd_rdy;
        dats[0] = bus.rd_data;
        bus.rd_req = 2'b00;
      end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 2'b00;
    check("burst_writes", wb, 4);
    check("burst_rdy", rdys[0], 2'b01);
    check("burst_data", dats[0], 8'h11);
    check("burst_resume", wa, 1);
    tick();

    do_write(9'd20, 8'h00, "w20z");
    bus.wr_addr = 9'd20;
    bus.wr_data = 8'h3C;
    bus.rd_addr[9 +: 9] = 9'd20;
    bus.wr_req = 1'b1;
    bus.rd_req = 2'b10;
    ac = 0;
    rc = 0;
    n = 0;
    rdys[0] = '0;
    dats[0] = '0;
    while (rc == 0 && n < 20) begin
      tick();
      n++;
      if (bus.wr_ack && ac == 0) begin
        ac = n;
        bus.wr_req = 1'b0;
      end
      if (bus.rd_rdy != 0) begin
        rc = n;
        rdys[0] = bus.rd_rdy;
        dats[0] = bus.rd_data;
        bus.rd_req = 2'b00;
      end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 2'b00;
    check("conf_order", (ac != 0 && ac < rc), 1);
    check("conf_rdy", rdys[0], 2'b10);
    check("conf_data", dats[0], 8'h3C);
    tick();

    do_write(9'd0, 8'h0A, "w0");
    do_write(9'd431, 8'h43, "w431");
    do_write(9'd432, 8'hFF, "w432");
    do_read(0, 9'd432, 8'h00, "r432");
    do_read(0, 9'd0, 8'h0A, "r0");
    do_read(0, 9'd431, 8'h43, "r431");

    bus.rd_addr[0 +: 9] = 9'd5;
    bus.rd_addr[9 +: 9] = 9'd226;
    bus.rd_req = 2'b11;
    tick();
    check("mid_busy", bus.busy, 1);
    check("mid_rdy", bus.rd_rdy, 0);
    resetn = 1'b0;
    #1;
    check("mrst_busy", bus.busy, 0);
    check("mrst_rdy", bus.rd_rdy, 0);
    check("mrst_ack", bus.wr_ack, 0);
    check("mrst_data", bus.rd_data, 0);
    tick();
    tick();
    check("mrst_rdy_hold", bus.rd_rdy, 0);
    resetn = 1'b1;
    k = 0;
    n = 0;
    while (k < 2 && n < 20) begin
      tick();
      n++;
      if (bus.rd_rdy != 0) begin
        rdys[k] = bus.rd_rdy;
        dats[k] = bus.rd_data;
        bus.rd_req = bus.rd_req & ~bus.rd_rdy;
        k++;
      end
    end
    bus.rd_req = 2'b00;
    check("post_count", k, 2);
    check("post_rdy0", rdys[0], 2'b01);
    check("post_data0", dats[0], 8'hA5);
    check("post_rdy1", rdys[1], 2'b10);
    check("post_data1", dats[1], 8'h22);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
